// File: rtl/adpcm_main_udiv_seq.sv
// Sequential restoring divider (N-bit dividend / M-bit divisor), one quotient bit per clock, ap_start/ap_done handshake.
// Latency N+1 cycles from accept to ap_done; ap_start ignored while BUSY. Optional macro: ADPCM_UDIV_DIVZERO_EN.
module adpcm_main_udiv_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 27,
  parameter int din1_WIDTH = 11,
  parameter int dout_WIDTH = 15
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dz
);
  localparam int N  = din0_WIDTH;
  localparam int M  = din1_WIDTH;
  localparam int Q  = dout_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [N-1:0]    r_dvd;
  logic [M-1:0]    r_dvsr;
  logic [M-1:0]    r_part;
  logic [N-1:0]    r_quot;
  logic [CW-1:0]   r_cnt;
  logic [Q-1:0]    r_dout;
  logic [M-1:0]    r_rem;
  logic            r_ovf;
  logic            r_dz;

  logic            w_accept;
  logic            w_last;
  logic            w_zero_div;
  logic [M:0]      w_trial;
  logic            w_ge;
  logic [M-1:0]    w_diff;
  logic [M-1:0]    w_part_nxt;
  logic [N-1:0]    w_quot_nxt;
  logic            w_unused_id;

  assign w_unused_id = (ID != 0);

  assign w_accept = ap_start && (r_state != S_BUSY);
  assign w_last   = (r_cnt == CW'(N - 1));

`ifdef ADPCM_UDIV_DIVZERO_EN
  assign w_zero_div = (din1 == '0);
`else
  assign w_zero_div = 1'b0;
`endif

  // The restored remainder is always below the divisor, so M bits hold it;
  // only the trial value needs the extra top bit.
  assign w_trial    = {r_part, r_dvd[N-1]};
  assign w_ge       = w_trial[M] || (w_trial[M-1:0] >= r_dvsr);
  assign w_diff     = w_trial[M-1:0] - r_dvsr;
  assign w_part_nxt = w_ge ? w_diff : w_trial[M-1:0];
  assign w_quot_nxt = {r_quot[N-2:0], w_ge};

  always_ff @(posedge ap_clk) begin
    if (ap_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)               w_state_nxt = w_zero_div ? S_DONE : S_BUSY;
        else if (r_state == S_DONE) w_state_nxt = S_IDLE;
      end
      S_BUSY:  if (w_last) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_dvd  <= '0;
      r_dvsr <= '0;
      r_part <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_dout <= '0;
      r_rem  <= '0;
      r_ovf  <= 1'b0;
      r_dz   <= 1'b0;
    end else if (w_accept) begin
      r_dvd  <= din0;
      r_dvsr <= din1;
      r_part <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
`ifdef ADPCM_UDIV_DIVZERO_EN
      if (w_zero_div) begin
        r_dout <= '1;
        r_rem  <= din0[M-1:0];
        r_ovf  <= 1'b1;
        r_dz   <= 1'b1;
      end
`endif
    end else if (r_state == S_BUSY) begin
      r_dvd  <= {r_dvd[N-2:0], 1'b0};
      r_part <= w_part_nxt;
      r_quot <= w_quot_nxt;
      r_cnt  <= r_cnt + 1'b1;
      // Results are captured on the final step so they are valid in DONE.
      if (w_last) begin
        r_dout <= w_quot_nxt[Q-1:0];
        r_rem  <= w_part_nxt;
        r_ovf  <= |w_quot_nxt[N-1:Q];
        r_dz   <= 1'b0;
      end
    end
  end

  assign ap_idle  = (r_state == S_IDLE);
  assign ap_done  = (r_state == S_DONE);
  assign ap_ready = (r_state == S_DONE);
  assign dout     = r_dout;
  assign rem      = r_rem;
  assign ovf      = r_ovf;
  assign dz       = r_dz;
endmodule
